// File: rtl/health_bar_renderer_pkg.sv
// ---------------------------------------------------------------------------
// health_bar_renderer_pkg
// Shared types and defaults for the health-bar overlay: the trail animation
// state encoding, default pixel coordinate / color widths, and the default
// palette used by the renderer.
// ---------------------------------------------------------------------------
package health_bar_renderer_pkg;

  // Trail animation states.
  //   ST_IDLE  : bar at rest, trail == hp_shown
  //   ST_HOLD  : trail frozen after damage, counting hold frames
  //   ST_DRAIN : trail shrinking toward hp_shown
  //   ST_FILL  : hp_shown ramping up toward the target after healing
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FILL  = 2'd3
  } anim_state_e;

  localparam int DEF_COORD_W = 10;
  localparam int DEF_COLOR_W = 12;

  // RGB 4:4:4 defaults.
  localparam logic [11:0] DEF_FILL_COLOR   = 12'hE00;
  localparam logic [11:0] DEF_TRAIL_COLOR  = 12'hF80;
  localparam logic [11:0] DEF_BORDER_COLOR = 12'hFFF;

endpackage

// File: rtl/health_bar_anim.sv
// ---------------------------------------------------------------------------
// health_bar_anim
// Health value animation for the health bar. Samples the game-logic health
// once per frame (on frame_tick), clamps it to MAX_HP, and animates two
// values read by the pixel path:
//   hp_shown : the solid fill level, drops instantly on damage and ramps
//              up one unit per frame on heal
//   trail    : the ghost level, holds HOLD_FRAMES frames after damage and
//              then drains one unit every DRAIN_DIV frames
// Invariant: hp_shown <= trail <= MAX_HP.
//
// Ports
//   clk         in   pixel clock
//   reset_n     in   asynchronous active-low reset
//   frame_tick  in   one-cycle pulse at start of vertical blanking
//   hp_target   in   game-logic health (HP_W bits, clamped to MAX_HP)
//   hp_shown    out  displayed fill level
//   trail       out  displayed trail level
//   drain_busy  out  animation in progress (state != IDLE)
// ---------------------------------------------------------------------------
module health_bar_anim
  import health_bar_renderer_pkg::*;
#(
  parameter int HP_W        = 7,
  parameter int MAX_HP      = 100,
  parameter int HOLD_FRAMES = 20,
  parameter int DRAIN_DIV   = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            frame_tick,
  input  logic [HP_W-1:0] hp_target,
  output logic [HP_W-1:0] hp_shown,
  output logic [HP_W-1:0] trail,
  output logic            drain_busy
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam int DIV_W  = $clog2(DRAIN_DIV + 1);

  localparam logic [HP_W-1:0]   HP_MAX   = HP_W'(MAX_HP);
  localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [DIV_W-1:0]  DIV_END  = DIV_W'(DRAIN_DIV - 1);

  anim_state_e       state_q, state_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic [HP_W-1:0]   trail_q, trail_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [DIV_W-1:0]  div_q, div_d;

  logic [HP_W-1:0]   target;
  logic [HP_W-1:0]   hp_inc;
  logic [HP_W-1:0]   trail_dec;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      hp_q    <= HP_MAX;
      trail_q <= HP_MAX;
      hold_q  <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      trail_q <= trail_d;
      hold_q  <= hold_d;
      div_q   <= div_d;
    end
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    hp_d      = hp_q;
    trail_d   = trail_q;
    hold_d    = hold_q;
    div_d     = div_q;

    target    = (hp_target > HP_MAX) ? HP_MAX : hp_target;
    hp_inc    = hp_q + HP_W'(1);
    trail_dec = trail_q - HP_W'(1);

    if (frame_tick) begin
      if (target < hp_q) begin
        // Damage: fill drops at once, trail keeps the old (higher) level and
        // the hold window restarts even if a drain was under way.
        hp_d    = target;
        hold_d  = '0;
        state_d = ST_HOLD;
      end else if ((target > hp_q) && (state_q != ST_FILL)) begin
        // Heal entry: the trail collapses onto the fill so no ghost segment
        // is drawn while the bar grows.
        trail_d = hp_q;
        state_d = ST_FILL;
      end else begin
        unique case (state_q)
          ST_HOLD: begin
            if (hold_q == HOLD_END) begin
              div_d   = '0;
              state_d = ST_DRAIN;
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
          ST_DRAIN: begin
            if (trail_q == hp_q) begin
              state_d = ST_IDLE;
            end else if (div_q == DIV_END) begin
              div_d   = '0;
              trail_d = trail_dec;
              if (trail_dec == hp_q) state_d = ST_IDLE;
            end else begin
              div_d = div_q + DIV_W'(1);
            end
          end
          ST_FILL: begin
            if (target > hp_q) begin
              hp_d    = hp_inc;
              trail_d = hp_inc;
              if (hp_inc == target) state_d = ST_IDLE;
            end else begin
              state_d = ST_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign hp_shown   = hp_q;
  assign trail      = trail_q;
  assign drain_busy = (state_q != ST_IDLE);

endmodule

// File: rtl/health_bar_renderer.sv
// ---------------------------------------------------------------------------
// health_bar_renderer
// Screen-positioned health-bar overlay for the VGA pixel pipeline. Draws a
// one-pixel border around an interior of (MAX_HP*PX_PER_HP) x BAR_H pixels.
// The interior shows a fill segment (hp_shown), a ghost trail segment
// (trail) and empty black pixels. MIRROR=1 anchors the fill at the right.
// The compositor selects color_data whenever pixel_on is set.
//
// Pixel path latency is two clocks from x/y to color_data/pixel_on:
//   stage 1: local coordinates and in-box flag
//   stage 2: border / fill / trail / empty classification
//
// Ports
//   clk         in   pixel clock
//   reset_n     in   asynchronous active-low reset
//   frame_tick  in   one-cycle pulse at start of vertical blanking
//   x, y        in   current pixel column / row (COORD_W bits)
//   hp_target   in   game-logic health (HP_W bits)
//   color_data  out  pixel color (COLOR_W bits), 0 outside the bar
//   pixel_on    out  pixel belongs to the bar
//   drain_busy  out  health animation in progress
// ---------------------------------------------------------------------------
module health_bar_renderer
  import health_bar_renderer_pkg::*;
#(
  parameter int                 COLOR_W      = DEF_COLOR_W,
  parameter int                 COORD_W      = DEF_COORD_W,
  parameter int                 HP_W         = 7,
  parameter int                 MAX_HP       = 100,
  parameter int                 PX_PER_HP    = 2,
  parameter int                 BAR_H        = 12,
  parameter int                 ORIGIN_X     = 16,
  parameter int                 ORIGIN_Y     = 16,
  parameter int                 MIRROR       = 0,
  parameter int                 HOLD_FRAMES  = 20,
  parameter int                 DRAIN_DIV    = 2,
  parameter logic [COLOR_W-1:0] FILL_COLOR   = DEF_FILL_COLOR,
  parameter logic [COLOR_W-1:0] TRAIL_COLOR  = DEF_TRAIL_COLOR,
  parameter logic [COLOR_W-1:0] BORDER_COLOR = DEF_BORDER_COLOR
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [HP_W-1:0]    hp_target,
  output logic [COLOR_W-1:0] color_data,
  output logic               pixel_on,
  output logic               drain_busy
);

  localparam int INT_W = MAX_HP * PX_PER_HP;  // interior width in pixels
  localparam int BOX_W = INT_W + 2;
  localparam int BOX_H = BAR_H + 2;

  logic [HP_W-1:0] hp_shown;
  logic [HP_W-1:0] trail;

  health_bar_anim #(
    .HP_W        (HP_W),
    .MAX_HP      (MAX_HP),
    .HOLD_FRAMES (HOLD_FRAMES),
    .DRAIN_DIV   (DRAIN_DIV)
  ) u_anim (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_tick  (frame_tick),
    .hp_target   (hp_target),
    .hp_shown    (hp_shown),
    .trail       (trail),
    .drain_busy  (drain_busy)
  );

  // -------------------------------------------------------------------------
  // Stage 1: local coordinates. One extra bit catches pixels left of / above
  // the origin as negative results.
  // -------------------------------------------------------------------------
  logic [COORD_W:0]   lx_full, ly_full;
  logic [COORD_W-1:0] lx_q, lx_d;
  logic [COORD_W-1:0] ly_q, ly_d;
  logic               in_box_q, in_box_d;

  always_comb begin
    lx_full  = {1'b0, x} - (COORD_W+1)'(ORIGIN_X);
    ly_full  = {1'b0, y} - (COORD_W+1)'(ORIGIN_Y);
    lx_d     = lx_full[COORD_W-1:0];
    ly_d     = ly_full[COORD_W-1:0];
    in_box_d = !lx_full[COORD_W] && !ly_full[COORD_W] &&
               (lx_d < COORD_W'(BOX_W)) && (ly_d < COORD_W'(BOX_H));
  end

  // -------------------------------------------------------------------------
  // Stage 2: classification. hp_shown and trail only change in blanking, so
  // reading them directly keeps every frame consistent.
  // -------------------------------------------------------------------------
  logic [COORD_W-1:0] ix;
  logic [COORD_W-1:0] fill_px;
  logic [COORD_W-1:0] trail_px;
  logic               border;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               on_q, on_d;

  always_comb begin
    // Mirrored column: INT_W-1-(lx-1) simplifies to INT_W-lx.
    if (MIRROR != 0) ix = COORD_W'(INT_W) - lx_q;
    else             ix = lx_q - COORD_W'(1);

    fill_px  = COORD_W'(hp_shown) * COORD_W'(PX_PER_HP);
    trail_px = COORD_W'(trail) * COORD_W'(PX_PER_HP);

    border = (lx_q == '0) || (ly_q == '0) ||
             (lx_q == COORD_W'(BOX_W - 1)) || (ly_q == COORD_W'(BOX_H - 1));

    color_d = '0;
    on_d    = 1'b0;
    if (in_box_q) begin
      on_d = 1'b1;
      if (border)             color_d = BORDER_COLOR;
      else if (ix < fill_px)  color_d = FILL_COLOR;
      else if (ix < trail_px) color_d = TRAIL_COLOR;
    end
  end

  // NOTE: pipeline registers are reset as well, so a reset mid-frame blanks
  // the output immediately instead of replaying stale pixels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lx_q     <= '0;
      ly_q     <= '0;
      in_box_q <= 1'b0;
      color_q  <= '0;
      on_q     <= 1'b0;
    end else begin
      lx_q     <= lx_d;
      ly_q     <= ly_d;
      in_box_q <= in_box_d;
      color_q  <= color_d;
      on_q     <= on_d;
    end
  end

  assign color_data = color_q;
  assign pixel_on   = on_q;

endmodule

// File: tb/tb_health_bar_renderer.sv
// ---------------------------------------------------------------------------
// tb_health_bar_renderer
// Directed bench for health_bar_renderer with default parameters, plus a
// second instance with MIRROR=1 sharing the same stimulus.
// ---------------------------------------------------------------------------
module tb_health_bar_renderer;
  import health_bar_renderer_pkg::*;

  localparam int OX = 16;
  localparam int OY = 16;

  logic        clk;
  logic        reset_n;
  logic        frame_tick;
  logic [9:0]  x, y;
  logic [6:0]  hp_target;
  logic [11:0] color_data, color_data_m;
  logic        pixel_on, pixel_on_m;
  logic        drain_busy, drain_busy_m;

  int n_vec = 0;
  int n_err = 0;

  health_bar_renderer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .x          (x),
    .y          (y),
    .hp_target  (hp_target),
    .color_data (color_data),
    .pixel_on   (pixel_on),
    .drain_busy (drain_busy)
  );

  health_bar_renderer #(.MIRROR(1)) dut_m (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .x          (x),
    .y          (y),
    .hp_target  (hp_target),
    .color_data (color_data_m),
    .pixel_on   (pixel_on_m),
    .drain_busy (drain_busy_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a pixel and wait out the two-stage latency; sample 1ns later.
  task automatic put(input int xx, input int yy);
    @(negedge clk);
    x = 10'(xx);
    y = 10'(yy);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  // Interior pixel ix (non-mirrored) sits at x = OX + 1 + ix.
  function automatic int ixx(input int ix);
    return OX + 1 + ix;
  endfunction

  initial begin
    reset_n    = 1'b0;
    frame_tick = 1'b0;
    x          = '0;
    y          = '0;
    hp_target  = 7'd100;
    repeat (3) @(posedge clk);
    #1;
    check("rst_color", 32'(color_data), 32'h0);
    check("rst_on", 32'(pixel_on), 32'd0);
    check("rst_busy", 32'(drain_busy), 32'd0);
    check("rst_hp", 32'(dut.u_anim.hp_shown), 32'd100);
    check("rst_trail", 32'(dut.u_anim.trail), 32'd100);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two-cycle latency: border pixel appears only on the second edge.
    @(negedge clk);
    x = 10'(OX);
    y = 10'(OY + 5);
    @(posedge clk); #1;
    check("lat1_color", 32'(color_data), 32'h0);
    @(posedge clk); #1;
    check("lat2_color", 32'(color_data), 32'hFFF);
    check("lat2_on", 32'(pixel_on), 32'd1);

    // Full bar: all 200 interior pixels filled.
    for (int i = 0; i < 200; i++) begin
      put(ixx(i), OY + 5);
      check($sformatf("full_px%0d", i), 32'(color_data), 32'hE00);
    end
    put(OX + 201, OY + 5);
    check("right_border", 32'(color_data), 32'hFFF);
    put(OX + 100, OY);
    check("top_border", 32'(color_data), 32'hFFF);
    put(OX + 100, OY + 13);
    check("bot_border", 32'(color_data), 32'hFFF);
    put(OX + 202, OY + 5);
    check("outside_r_on", 32'(pixel_on), 32'd0);
    check("outside_r_color", 32'(color_data), 32'h0);
    put(OX - 1, OY + 5);
    check("outside_l_on", 32'(pixel_on), 32'd0);
    put(OX + 50, OY + 14);
    check("outside_b_on", 32'(pixel_on), 32'd0);

    // Damage to 60: hold 20 frames, drain 40 HP over 80 frames.
    hp_target = 7'd60;
    tick(1);
    check("dmg_hp", 32'(dut.u_anim.hp_shown), 32'd60);
    check("dmg_trail", 32'(dut.u_anim.trail), 32'd100);
    check("dmg_state", 32'(dut.u_anim.state_q), 32'(ST_HOLD));
    check("dmg_busy", 32'(drain_busy), 32'd1);
    put(ixx(119), OY + 5);
    check("dmg_px119", 32'(color_data), 32'hE00);
    put(ixx(120), OY + 5);
    check("dmg_px120", 32'(color_data), 32'hF80);
    put(ixx(199), OY + 5);
    check("dmg_px199", 32'(color_data), 32'hF80);
    tick(19);
    check("hold19_state", 32'(dut.u_anim.state_q), 32'(ST_HOLD));
    tick(1);
    check("hold20_state", 32'(dut.u_anim.state_q), 32'(ST_DRAIN));
    check("hold20_trail", 32'(dut.u_anim.trail), 32'd100);
    tick(2);
    check("drain2_trail", 32'(dut.u_anim.trail), 32'd99);
    tick(77);
    check("drain79_trail", 32'(dut.u_anim.trail), 32'd61);
    check("drain79_busy", 32'(drain_busy), 32'd1);
    tick(1);
    check("drain80_trail", 32'(dut.u_anim.trail), 32'd60);
    check("drain80_busy", 32'(drain_busy), 32'd0);
    put(ixx(120), OY + 5);
    check("idle_px120", 32'(color_data), 32'h0);
    check("idle_px120_on", 32'(pixel_on), 32'd1);

    // Asynchronous reset in the middle of a drain.
    hp_target = 7'd30;
    tick(25);
    check("pre_rst_state", 32'(dut.u_anim.state_q), 32'(ST_DRAIN));
    put(ixx(10), OY + 5);
    check("pre_rst_px", 32'(color_data), 32'hE00);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_color", 32'(color_data), 32'h0);
    check("arst_on", 32'(pixel_on), 32'd0);
    check("arst_busy", 32'(drain_busy), 32'd0);
    hp_target = 7'd100;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    put(ixx(150), OY + 5);
    check("post_rst_px150", 32'(color_data), 32'hE00);
    check("post_rst_hp", 32'(dut.u_anim.hp_shown), 32'd100);
    check("post_rst_trail", 32'(dut.u_anim.trail), 32'd100);

    // Re-damage during drain restarts the hold.
    hp_target = 7'd70;
    tick(21);
    tick(40);
    check("redmg_pre_trail", 32'(dut.u_anim.trail), 32'd80);
    check("redmg_pre_state", 32'(dut.u_anim.state_q), 32'(ST_DRAIN));
    hp_target = 7'd40;
    tick(1);
    check("redmg_hp", 32'(dut.u_anim.hp_shown), 32'd40);
    check("redmg_trail", 32'(dut.u_anim.trail), 32'd80);
    check("redmg_state", 32'(dut.u_anim.state_q), 32'(ST_HOLD));
    tick(19);
    check("redmg_h19_state", 32'(dut.u_anim.state_q), 32'(ST_HOLD));
    check("redmg_h19_trail", 32'(dut.u_anim.trail), 32'd80);
    tick(1);
    check("redmg_h20_state", 32'(dut.u_anim.state_q), 32'(ST_DRAIN));

    // Heal 40 -> 50 while draining: trail collapses, fill ramps 1/frame.
    hp_target = 7'd50;
    tick(1);
    check("heal_state", 32'(dut.u_anim.state_q), 32'(ST_FILL));
    check("heal_hp", 32'(dut.u_anim.hp_shown), 32'd40);
    check("heal_trail", 32'(dut.u_anim.trail), 32'd40);
    put(ixx(80), OY + 5);
    check("heal_px80", 32'(color_data), 32'h0);
    check("heal_px80_on", 32'(pixel_on), 32'd1);
    tick(1);
    check("heal1_hp", 32'(dut.u_anim.hp_shown), 32'd41);
    check("heal1_trail", 32'(dut.u_anim.trail), 32'd41);
    tick(8);
    check("heal9_hp", 32'(dut.u_anim.hp_shown), 32'd49);
    check("heal9_busy", 32'(drain_busy), 32'd1);
    tick(1);
    check("heal10_hp", 32'(dut.u_anim.hp_shown), 32'd50);
    check("heal10_busy", 32'(drain_busy), 32'd0);
    put(ixx(99), OY + 5);
    check("heal_px99", 32'(color_data), 32'hE00);
    put(ixx(100), OY + 5);
    check("heal_px100", 32'(color_data), 32'h0);

    // Out-of-range target clamps to MAX_HP.
    hp_target = 7'd127;
    tick(1);
    check("clamp_state", 32'(dut.u_anim.state_q), 32'(ST_FILL));
    tick(50);
    check("clamp_hp", 32'(dut.u_anim.hp_shown), 32'd100);
    check("clamp_busy", 32'(drain_busy), 32'd0);
    tick(3);
    check("clamp_hold_hp", 32'(dut.u_anim.hp_shown), 32'd100);
    check("clamp_hold_trail", 32'(dut.u_anim.trail), 32'd100);
    check("clamp_hold_busy", 32'(drain_busy), 32'd0);

    // Settle at 50 (hold 20 + drain 100 frames), then compare both layouts.
    hp_target = 7'd50;
    tick(121);
    check("mir_busy", 32'(drain_busy_m), 32'd0);
    check("mir_trail", 32'(dut_m.u_anim.trail), 32'd50);
    put(OX + 1, OY + 5);
    check("mir_left_color", 32'(color_data_m), 32'h0);
    check("mir_left_on", 32'(pixel_on_m), 32'd1);
    check("nom_left_color", 32'(color_data), 32'hE00);
    put(OX + 100, OY + 5);
    check("mir_lx100_color", 32'(color_data_m), 32'h0);
    check("nom_lx100_color", 32'(color_data), 32'hE00);
    put(OX + 101, OY + 5);
    check("mir_lx101_color", 32'(color_data_m), 32'hE00);
    check("nom_lx101_color", 32'(color_data), 32'h0);
    put(OX + 200, OY + 5);
    check("mir_right_color", 32'(color_data_m), 32'hE00);
    put(OX, OY + 5);
    check("mir_border", 32'(color_data_m), 32'hFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/health_bar_renderer.md
Name: health_bar_renderer

Overview:
- Parametrised successor to the fixed 64x64 health-bar sprite ROMs.
- Draws a player health bar as a screen-positioned overlay. The bar has a border, a fill segment and a damage "trail" (ghost) segment. The trail drains after damage; healing makes the fill ramp up.
- Sits in the VGA pixel pipeline beside the fighter sprite ROMs. Its color output is muxed by the top-level compositor using pixel_on.

Parameters:
- COLOR_W, 12, color width (RGB 4:4:4)
- COORD_W, 10, pixel coordinate width
- HP_W, 7, health value width
- MAX_HP, 100, full health; reset fill value
- PX_PER_HP, 2, interior pixels per HP unit; interior width = MAX_HP*PX_PER_HP
- BAR_H, 12, interior height in pixels
- ORIGIN_X, 16, left edge of border
- ORIGIN_Y, 16, top edge of border
- MIRROR, 0, 0 = fill grows from left; 1 = fill anchored right (player 2)
- HOLD_FRAMES, 20, frames the trail holds before draining
- DRAIN_DIV, 2, frames per 1-HP trail decrement
- FILL_COLOR, 12'hE00
- TRAIL_COLOR, 12'hF80
- BORDER_COLOR, 12'hFFF

Ports:
- clk, in, 1, pixel clock
- reset_n, in, 1, asynchronous active-low reset
- frame_tick, in, 1, one-cycle pulse at start of vertical blanking
- x, in, COORD_W, current pixel column
- y, in, COORD_W, current pixel row
- hp_target, in, HP_W, game-logic health
- color_data, out, COLOR_W, pixel color
- pixel_on, out, 1, pixel belongs to the bar (border, fill, trail or empty interior)
- drain_busy, out, 1, animation in progress (state != IDLE)

Behaviour:
- Reset (async, reset_n low): hp_shown = MAX_HP, trail = MAX_HP, state IDLE, hold/div counters 0, color_data 0, pixel_on 0, drain_busy 0. Pipeline registers are cleared. Reset mid-frame gives black/off output until the pipeline refills.
- hp_target is sampled only on frame_tick, so there is no tearing within a frame. Values > MAX_HP clamp to MAX_HP.
- FSM states IDLE, HOLD, DRAIN, FILL. All transitions happen only on frame_tick. Let t be the clamped target.
  - Any state, t < hp_shown (damage): hp_shown <= t; trail unchanged (keeps its higher value); hold counter <= 0; go to HOLD.
  - Any state, t > hp_shown (heal): go to FILL; trail <= hp_shown.
  - HOLD: hold counter increments each tick. At HOLD_FRAMES-1, go to DRAIN with div counter 0.
  - DRAIN: div counter increments each tick. At DRAIN_DIV-1 it wraps and trail decrements by 1. When trail == hp_shown, go to IDLE.
  - FILL: hp_shown increments by 1 per tick, with trail == hp_shown. When hp_shown == t, go to IDLE.
  - t == hp_shown: no change to hp_shown. HOLD, DRAIN and FILL continue their sequences.
- Invariant: hp_shown <= trail <= MAX_HP at all times.
- Pixel path, 2-cycle latency from x/y to outputs:
  - Stage 1 registers local coordinates lx = x-ORIGIN_X and ly = y-ORIGIN_Y, plus an in-box flag. The box is (MAX_HP*PX_PER_HP+2) x (BAR_H+2).
  - Stage 2 classifies the pixel.
  - Border: lx==0, ly==0, last column or last row.
  - Interior column ix = lx-1; for MIRROR=1 it is mirrored, ix = MAX_HP*PX_PER_HP-1-(lx-1).
  - ix < hp_shown*PX_PER_HP gives FILL_COLOR. Otherwise ix < trail*PX_PER_HP gives TRAIL_COLOR. Otherwise color 0 (pixel_on still 1).
  - Outside the box: pixel_on 0, color_data 0.
- Arithmetic: local-coordinate subtraction is done in COORD_W+1 bits; a negative result means outside the box. hp*PX_PER_HP is a constant multiply at COORD_W width.
- The pixel path reads the hp_shown/trail registers directly. Updates happen in blanking, so no frame shows a mixed state.

Decomposition:
- Shared package: FSM state enum (IDLE/HOLD/DRAIN/FILL), color constants (FILL/TRAIL/BORDER defaults), COORD_W.
- One sub-module, health_bar_anim: FSM, hp_shown, trail and counters. It outputs hp_shown, trail and drain_busy.
- The top keeps the 2-stage pixel classifier.

Test Plan:
- Release reset_n, no ticks, scan x=ORIGIN_X+1..ORIGIN_X+200 at y=ORIGIN_Y+5 -> all 200 interior pixels FILL_COLOR 12'hE00; x=ORIGIN_X gives 12'hFFF; output appears 2 cycles after x.
- hp_target=60, one tick -> hp_shown=60, trail=100, state HOLD. Interior px 120..199 are 12'hF80. After 20 more ticks state is DRAIN. Trail reaches 60 after a further 80 ticks; drain_busy then falls.
- During DRAIN at trail=80, hp_target=40 -> hp_shown=40 immediately, trail stays 80, hold restarts (20 frames).
- From hp_shown=40, hp_target=50 -> FILL. hp_shown goes 41..50 over 10 ticks, no trail pixels, then IDLE.
- MIRROR=1, hp_shown=50 -> fill occupies the rightmost 100 interior pixels; the left 100 are color 0 with pixel_on=1.
- hp_target=127 -> clamps to 100. Asserting reset_n low mid-DRAIN -> outputs 0 asynchronously; after release the bar shows full.
